// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin arbiter sharing one data-memory port between two cores.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [2:0]        c0_mask,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_err,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  input  logic [2:0]        c1_mask,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_mask,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(MEM_WORDS);

  state_t            state;
  state_t            state_nxt;
  logic              owner_nxt;
  logic              last;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_mask;
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic [DATA_W-1:0] rdata_sel;

  assign sel_we    = owner ? c1_we    : c0_we;
  assign sel_addr  = owner ? c1_addr  : c0_addr;
  assign sel_wdata = owner ? c1_wdata : c0_wdata;
  assign sel_mask  = owner ? c1_mask  : c0_mask;

  assign word_idx  = {2'b00, sel_addr[ADDR_W-1:2]};
  assign in_range  = (word_idx < WORD_LIMIT);
  assign rdata_sel = (in_range && !sel_we) ? mem_rdata : '0;
  assign busy      = (state != IDLE);

  // Memory port is decoded from state so a reset aborts an access instantly.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (c0_req && c1_req) begin
          owner_nxt = ~last;
          state_nxt = ACCESS;
        end else if (c0_req) begin
          owner_nxt = 1'b0;
          state_nxt = ACCESS;
        end else if (c1_req) begin
          owner_nxt = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = sel_addr;
        mem_wdata = sel_wdata;
        mem_mask  = sel_mask;
        mem_wr_en = sel_we & in_range;
        mem_rd_en = ~sel_we & in_range;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (state == ACCESS) last <= owner;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c0_ack   <= 1'b0;
      c1_ack   <= 1'b0;
      c0_err   <= 1'b0;
      c1_err   <= 1'b0;
      c0_rdata <= '0;
      c1_rdata <= '0;
    end else begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      c0_err <= 1'b0;
      c1_err <= 1'b0;
      if (state == ACCESS) begin
        if (owner) begin
          c1_ack   <= 1'b1;
          c1_err   <= ~in_range;
          c1_rdata <= rdata_sel;
        end else begin
          c0_ack   <= 1'b1;
          c0_err   <= ~in_range;
          c0_rdata <= rdata_sel;
        end
      end
    end
  end

endmodule
`default_nettype wire
